// File: rtl/rr_arb_mux.sv
// Registered N-channel round-robin arbitrating mux with a valid/ready handshake on every port.
// Optional packet lock (grant held until in_last) is compiled in with `define ARB_PKT_LOCK_EN.
module rr_arb_mux #(
  parameter int NUM_CH = 4,
  parameter int DATA_W = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_CH-1:0]        in_valid,
  input  logic [NUM_CH*DATA_W-1:0] in_data,
  input  logic [NUM_CH-1:0]        in_last,
  output logic [NUM_CH-1:0]        in_ready,
  output logic                     out_valid,
  output logic [DATA_W-1:0]        out_data,
  output logic [NUM_CH-1:0]        out_sel,
  output logic                     out_last,
  input  logic                     out_ready
);

  localparam int PTR_W = (NUM_CH > 2) ? $clog2(NUM_CH) : 1;
  localparam logic [PTR_W:0]   NUM_CH_W = (PTR_W+1)'(NUM_CH);
  localparam logic [PTR_W-1:0] LAST_CH  = PTR_W'(NUM_CH - 1);

  logic [PTR_W-1:0]  ptr_q, ptr_d;
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic [NUM_CH-1:0] out_sel_q, out_sel_d;
  logic              out_last_q, out_last_d;

  logic [PTR_W:0]    sum_s;
  logic [PTR_W-1:0]  idx_s;
  logic              hit_s;
  logic              rr_any_s;
  logic [PTR_W-1:0]  rr_idx_s;
  logic              gnt_any_s;
  logic [PTR_W-1:0]  gnt_idx_s;
  logic [NUM_CH-1:0] grant_s;
  logic [DATA_W-1:0] sel_data_s;
  logic              sel_last_s;
  logic              load_s;
  logic              xfer_s;

`ifdef ARB_PKT_LOCK_EN
  logic              lock_q, lock_d;
  logic [PTR_W-1:0]  lock_ch_q, lock_ch_d;
`endif

  // Round-robin search from ptr, optionally overridden by the packet lock, then data select.
  always_comb begin
    sum_s      = '0;
    idx_s      = '0;
    hit_s      = 1'b0;
    rr_any_s   = 1'b0;
    rr_idx_s   = '0;
    grant_s    = '0;
    sel_data_s = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      sum_s = {1'b0, ptr_q} + (PTR_W+1)'(k);
      if (sum_s >= NUM_CH_W) begin
        idx_s = PTR_W'(sum_s - NUM_CH_W);
      end else begin
        idx_s = sum_s[PTR_W-1:0];
      end
      hit_s    = in_valid[idx_s] & ~rr_any_s;
      rr_idx_s = hit_s ? idx_s : rr_idx_s;
      rr_any_s = rr_any_s | hit_s;
    end
`ifdef ARB_PKT_LOCK_EN
    gnt_any_s = lock_q ? in_valid[lock_ch_q] : rr_any_s;
    gnt_idx_s = lock_q ? lock_ch_q : rr_idx_s;
`else
    gnt_any_s = rr_any_s;
    gnt_idx_s = rr_idx_s;
`endif
    for (int i = 0; i < NUM_CH; i++) begin
      grant_s[i] = gnt_any_s & (gnt_idx_s == PTR_W'(i));
      sel_data_s = sel_data_s | (in_data[i*DATA_W +: DATA_W] & {DATA_W{grant_s[i]}});
    end
    sel_last_s = |(grant_s & in_last);
  end

  assign load_s   = ~out_valid_q | out_ready;
  assign in_ready = grant_s & {NUM_CH{load_s & ~rst}};
  assign xfer_s   = |in_ready;

  // Output register and rotation pointer next-state.
  always_comb begin
    ptr_d       = ptr_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_sel_d   = out_sel_q;
    out_last_d  = out_last_q;
`ifdef ARB_PKT_LOCK_EN
    lock_d      = lock_q;
    lock_ch_d   = lock_ch_q;
`endif
    if (xfer_s) begin
      out_valid_d = 1'b1;
      out_data_d  = sel_data_s;
      out_sel_d   = grant_s;
      out_last_d  = sel_last_s;
      if (gnt_idx_s == LAST_CH) begin
        ptr_d = '0;
      end else begin
        ptr_d = gnt_idx_s + PTR_W'(1);
      end
`ifdef ARB_PKT_LOCK_EN
      // A word without last opens (or continues) a packet on this channel.
      lock_d    = ~sel_last_s;
      lock_ch_d = gnt_idx_s;
`endif
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sel_q   <= '0;
      out_last_q  <= 1'b0;
`ifdef ARB_PKT_LOCK_EN
      lock_q      <= 1'b0;
      lock_ch_q   <= '0;
`endif
    end else begin
      ptr_q       <= ptr_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sel_q   <= out_sel_d;
      out_last_q  <= out_last_d;
`ifdef ARB_PKT_LOCK_EN
      lock_q      <= lock_d;
      lock_ch_q   <= lock_ch_d;
`endif
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sel   = out_sel_q;
  assign out_last  = out_last_q;

endmodule

// File: tb/tb_rr_arb_mux.sv
// Directed-vector bench for rr_arb_mux (NUM_CH=4, DATA_W=8); lock expectations follow ARB_PKT_LOCK_EN.
module tb_rr_arb_mux;

  logic        clk;
  logic        rst;
  logic [3:0]  in_valid;
  logic [31:0] in_data;
  logic [3:0]  in_last;
  logic [3:0]  in_ready;
  logic        out_valid;
  logic [7:0]  out_data;
  logic [3:0]  out_sel;
  logic        out_last;
  logic        out_ready;

  int n_vec;
  int n_err;

  rr_arb_mux #(.NUM_CH(4), .DATA_W(8)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_data(in_data), .in_last(in_last), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_sel(out_sel), .out_last(out_last),
    .out_ready(out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [3:0] rr_sel_exp [5];
  logic [7:0] rr_dat_exp [5];
  logic [3:0] lk_sel_exp [4];
  logic [7:0] lk_dat_exp [4];
  logic [3:0] lk_last0   [4];

  initial begin
    n_vec = 0;
    n_err = 0;
    rr_sel_exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    rr_dat_exp = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA0};
    lk_last0   = '{4'd0, 4'd0, 4'd1, 4'd1};
`ifdef ARB_PKT_LOCK_EN
    lk_sel_exp = '{4'b0001, 4'b0001, 4'b0001, 4'b0010};
    lk_dat_exp = '{8'hC0, 8'hC0, 8'hC0, 8'hC1};
`else
    lk_sel_exp = '{4'b0001, 4'b0010, 4'b0001, 4'b0010};
    lk_dat_exp = '{8'hC0, 8'hC1, 8'hC0, 8'hC1};
`endif

    // Reset with every channel requesting.
    rst = 1'b1; in_valid = 4'b1111; in_data = 32'hA3A2A1A0; in_last = 4'b1111; out_ready = 1'b1;
    #1;
    check_eq("rst_in_ready", in_ready, 4'b0000);
    step();
    check_eq("rst_in_ready_after", in_ready, 4'b0000);
    check_eq("rst_out_valid", out_valid, 1'b0);
    check_eq("rst_out_sel", out_sel, 4'b0000);
    check_eq("rst_out_data", out_data, 8'h00);
    check_eq("rst_out_last", out_last, 1'b0);

    // All channels valid: strict rotation at one word per cycle.
    rst = 1'b0;
    #1;
    check_eq("rr_in_ready0", in_ready, 4'b0001);
    for (int c = 0; c < 5; c++) begin
      step();
      check_eq("rr_out_valid", out_valid, 1'b1);
      check_eq("rr_out_sel", out_sel, rr_sel_exp[c]);
      check_eq("rr_out_data", out_data, rr_dat_exp[c]);
      check_eq("rr_out_last", out_last, 1'b1);
    end

    // Drain, then channel 2 alone with a stalled consumer.
    in_valid = 4'b0000;
    step();
    check_eq("drain_out_valid", out_valid, 1'b0);
    check_eq("drain_out_sel_hold", out_sel, 4'b0001);
    in_valid = 4'b0100; in_data = 32'h005C0000; in_last = 4'b0100; out_ready = 1'b0;
    #1;
    check_eq("bp_in_ready_empty", in_ready, 4'b0100);
    step();
    check_eq("bp_out_valid", out_valid, 1'b1);
    check_eq("bp_out_data", out_data, 8'h5C);
    check_eq("bp_out_sel", out_sel, 4'b0100);
    in_data = 32'h005D0000;
    for (int c = 0; c < 2; c++) begin
      check_eq("bp_in_ready_full", in_ready, 4'b0000);
      step();
      check_eq("bp_hold_data", out_data, 8'h5C);
      check_eq("bp_hold_valid", out_valid, 1'b1);
    end
    out_ready = 1'b1;
    #1;
    check_eq("bp_in_ready_drain", in_ready, 4'b0100);
    step();
    check_eq("bp_next_data", out_data, 8'h5D);
    check_eq("bp_next_valid", out_valid, 1'b1);

    // Pointer wrap: grant 3, then 1 (skipping invalid 0), then 3.
    in_valid = 4'b1000; in_data = 32'h33221100; in_last = 4'b1111;
    step();
    check_eq("wrap_sel3", out_sel, 4'b1000);
    check_eq("wrap_data3", out_data, 8'h33);
    in_valid = 4'b1010;
    #1;
    check_eq("wrap_in_ready1", in_ready, 4'b0010);
    step();
    check_eq("wrap_sel1", out_sel, 4'b0010);
    check_eq("wrap_data1", out_data, 8'h11);
    step();
    check_eq("wrap_sel3b", out_sel, 4'b1000);

    // Channel 0 packet (last = 0,0,1) against a continuously valid channel 1.
    in_valid = 4'b0011; in_data = 32'h0000C1C0;
    for (int c = 0; c < 4; c++) begin
      in_last = {3'b001, lk_last0[c][0]};
      step();
      check_eq("lock_out_sel", out_sel, lk_sel_exp[c]);
      check_eq("lock_out_data", out_data, lk_dat_exp[c]);
    end

    // Reset while a word is held: word discarded, pointer back to 0.
    in_valid = 4'b0010; in_data = 32'h0000B1B0; in_last = 4'b1111; out_ready = 1'b0;
    step();
    check_eq("mid_pre_sel", out_sel, 4'b0010);
    check_eq("mid_pre_valid", out_valid, 1'b1);
    rst = 1'b1; in_valid = 4'b0110; in_data = 32'h00B2B1B0;
    #1;
    check_eq("mid_rst_in_ready", in_ready, 4'b0000);
    step();
    check_eq("mid_rst_out_valid", out_valid, 1'b0);
    check_eq("mid_rst_out_sel", out_sel, 4'b0000);
    check_eq("mid_rst_out_data", out_data, 8'h00);
    rst = 1'b0; out_ready = 1'b1;
    #1;
    check_eq("post_rst_in_ready", in_ready, 4'b0010);
    step();
    check_eq("post_rst_sel", out_sel, 4'b0010);
    check_eq("post_rst_data", out_data, 8'hB1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/rr_arb_mux.md
# rr_arb_mux

Registered, parametrised N-channel data multiplexer with round-robin arbitration and a valid/ready handshake on every input and on the output. It generalises the one-hot bit-select mux from fixed external select and single-bit data to multi-bit channels, an internally generated one-hot grant with fair rotation, and a one-entry pipelined output register. It sits between several producer blocks and one shared downstream consumer.

## Interface
- NUM_CH, 4, number of input channels (≥2)
- DATA_W, 8, bits per channel data word
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- in_valid  input  NUM_CH  per-channel request
- in_data  input  NUM_CH*DATA_W  channel i occupies bits [i*DATA_W +: DATA_W]
- in_last  input  NUM_CH  end-of-packet flag per channel (used only with lock feature)
- in_ready  output  NUM_CH  per-channel accept; one-hot or zero
- out_valid  output  1  output register holds a word
- out_data  output  DATA_W  registered selected word
- out_sel  output  NUM_CH  one-hot source channel of out_data
- out_last  output  1  registered in_last of the source word
- out_ready  input  1  consumer accept

## Operation
- Single clock; reset is synchronous and active-high on rst.
- Reset values: out_valid=0, out_data=0, out_sel=0, out_last=0, rotation pointer ptr=0, lock=0.
- load = !out_valid | out_ready (combinational).
- grant: one-hot, first channel with in_valid=1 searching ptr, ptr+1, …, NUM_CH-1, 0, …, ptr-1; zero if no in_valid.
- in_ready = grant & {NUM_CH{load}}; in_ready never depends on in_ready itself; no combinational path from in_data.
- Transfer on channel i when in_valid[i] & in_ready[i]: next cycle out_valid=1, out_data=in_data[i], out_sel=one-hot i, out_last=in_last[i]; ptr ← (i+1) mod NUM_CH.
- No transfer and out_ready=1: out_valid ← 0; out_data/out_sel/out_last hold.
- No transfer and out_ready=0: all output registers hold (stable while out_valid=1).
- ptr updates only on a transfer; idle cycles keep ptr.
- Simultaneous drain and fill (out_valid=1, out_ready=1, transfer): register replaced, out_valid stays 1 — full throughput, one word per cycle.

## Timing
- Latency: input transfer at edge k → word visible on out_* after edge k, consumable from cycle k+1.
- Throughput: 1 word/cycle with out_ready held high.
- Fairness: with all channels continuously valid, grants cycle 0,1,…,NUM_CH-1 in order; each channel waits at most NUM_CH-1 transfers.
- rst asserted mid-operation: at the next edge all state returns to reset values; any in-flight output word is discarded; in_ready is 0 during the reset cycle.

## Configuration
- Macro ARB_PKT_LOCK_EN.
- Defined: lock register active. Transfer from channel i with in_last=0 sets lock and locked channel i; while locked, grant is forced to i (in_ready only to i, zero if in_valid[i]=0, other channels stall); transfer from i with in_last=1 clears lock; ptr still advances to i+1 after each transfer of i, so rotation resumes after the packet.
- Undefined: lock absent, arbitration per word; in_last only forwarded to out_last.

## Test plan
- Reset: drive rst=1 one cycle with all in_valid=1 → in_ready=0, out_valid=0, out_sel=0, out_data=0 after the edge.
- All four channels valid, data 0xA0..0xA3, out_ready=1 → out_sel 0001,0010,0100,1000,0001 on consecutive cycles, out_data 0xA0,0xA1,0xA2,0xA3,0xA0.
- Only channel 2 valid with data 0x5C, out_ready=0 for 3 cycles → one word captured, out_data=0x5C held, in_ready[2]=0 while full; out_ready=1 → next word accepted same cycle.
- Channels 1 and 3 valid after a channel-3 grant → channel 0 skipped (invalid), channel 1 granted next (ptr wrap from 3 to 0).
- ARB_PKT_LOCK_EN defined: channel 0 sends 3 words last=0,0,1 while channel 1 valid → out_sel=0001 three times, then 0010; undefined → alternates 0001,0010,0001,0010.
- rst asserted while out_valid=1 and out_ready=0 → out_valid=0 next cycle, ptr=0, first post-reset grant goes to lowest valid channel.
